row_col_loader: RTL and testbench



---
 rtl/row_col_loader.sv | 134 +++++++++++++
 tb/tb_row_col_loader.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/row_col_loader.sv
// Packs a serial element stream into row words and writes one row per memory address.
// Optional ROW_COL_LOADER_ERR_EN adds a sticky stream_err flag for data offered while idle.
module row_col_loader #(
    parameter int DATA_WIDTH   = 16,
    parameter int ROW_COL_SIZE = 16,
    parameter int MATRIX_SIZE  = 16,
    parameter int ADDR_BITS    = $clog2(MATRIX_SIZE)
) (
    input  logic                             clk,
    input  logic                             nreset,
    input  logic                             start,
    input  logic                             abort,
    input  logic                             in_valid,
    output logic                             in_ready,
    input  logic [DATA_WIDTH-1:0]            in_data,
    output logic [ADDR_BITS-1:0]             mem_address,
    output logic                             mem_write_enable,
    output logic [ROW_COL_SIZE*DATA_WIDTH-1:0] mem_datain,
    output logic                             busy,
    output logic                             done
`ifdef ROW_COL_LOADER_ERR_EN
    ,
    output logic                             stream_err
`endif
);

    localparam int CNT_W = (ROW_COL_SIZE > 1) ? $clog2(ROW_COL_SIZE) : 1;
    localparam int ROW_W = ROW_COL_SIZE * DATA_WIDTH;
    localparam logic [CNT_W-1:0]     CNT_LAST  = CNT_W'(ROW_COL_SIZE - 1);
    localparam logic [ADDR_BITS-1:0] ADDR_LAST = ADDR_BITS'(MATRIX_SIZE - 1);

    typedef enum logic [1:0] {IDLE, FILL, WRITE, DONE} state_t;

    state_t                 state, state_next;
    logic [CNT_W-1:0]       cnt, cnt_next;
    logic [ADDR_BITS-1:0]   row_addr, row_addr_next;
    logic [ROW_W-1:0]       pack, pack_next;
    logic [ADDR_BITS-1:0]   addr_q;
    logic [ROW_W-1:0]       data_q;
    logic                   load_out;

    always_comb begin
        state_next    = state;
        cnt_next      = cnt;
        row_addr_next = row_addr;
        pack_next     = pack;
        load_out      = 1'b0;
        case (state)
            IDLE: begin
                if (start && !abort) begin
                    state_next    = FILL;
                    cnt_next      = '0;
                    row_addr_next = '0;
                end
            end
            FILL: begin
                if (abort) begin
                    state_next    = IDLE;
                    cnt_next      = '0;
                    row_addr_next = '0;
                end else if (in_valid) begin
                    pack_next[int'(cnt)*DATA_WIDTH +: DATA_WIDTH] = in_data;
                    if (cnt == CNT_LAST) begin
                        state_next = WRITE;
                        cnt_next   = '0;
                        load_out   = 1'b1;
                    end else begin
                        cnt_next = cnt + 1'b1;
                    end
                end
            end
            WRITE: begin
                if (abort) begin
                    state_next    = IDLE;
                    cnt_next      = '0;
                    row_addr_next = '0;
                end else if (row_addr == ADDR_LAST) begin
                    state_next = DONE;
                end else begin
                    state_next    = FILL;
                    row_addr_next = row_addr + 1'b1;
                end
            end
            DONE: begin
                state_next    = IDLE;
                cnt_next      = '0;
                row_addr_next = '0;
            end
            default: state_next = IDLE;
        endcase
    end

    // Output address/data are captured as the row completes so they hold steady outside WRITE.
    always_ff @(posedge clk) begin
        if (!nreset) begin
            state    <= IDLE;
            cnt      <= '0;
            row_addr <= '0;
            pack     <= '0;
            addr_q   <= '0;
            data_q   <= '0;
        end else begin
            state    <= state_next;
            cnt      <= cnt_next;
            row_addr <= row_addr_next;
            pack     <= pack_next;
            if (load_out) begin
                addr_q <= row_addr;
                data_q <= pack_next;
            end
        end
    end

`ifdef ROW_COL_LOADER_ERR_EN
    always_ff @(posedge clk) begin
        if (!nreset) begin
            stream_err <= 1'b0;
        end else if (state == IDLE && start && !abort) begin
            stream_err <= 1'b0;
        end else if (state == IDLE && in_valid) begin
            stream_err <= 1'b1;
        end
    end
`endif

    // abort gates the strobes directly so a write or done in the abort cycle is cancelled.
    assign in_ready         = (state == FILL);
    assign busy             = (state != IDLE);
    assign mem_write_enable = (state == WRITE) && !abort;
    assign done             = (state == DONE) && !abort;
    assign mem_address      = addr_q;
    assign mem_datain       = data_q;

endmodule

// File: tb/tb_row_col_loader.sv
// Scoreboard bench for row_col_loader (DATA_WIDTH=8, ROW_COL_SIZE=4, MATRIX_SIZE=4).
module tb_row_col_loader;
    localparam int DW = 8;
    localparam int RC = 4;
    localparam int MS = 4;
    localparam int AB = 2;

    logic          clk = 1'b0;
    logic          nreset, start, abort, in_valid, in_ready;
    logic [DW-1:0] in_data;
    logic [AB-1:0] mem_address;
    logic          mem_write_enable;
    logic [RC*DW-1:0] mem_datain;
    logic          busy, done;
`ifdef ROW_COL_LOADER_ERR_EN
    logic          stream_err;
`endif

    row_col_loader #(.DATA_WIDTH(DW), .ROW_COL_SIZE(RC), .MATRIX_SIZE(MS), .ADDR_BITS(AB)) dut (
        .clk(clk), .nreset(nreset), .start(start), .abort(abort),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .mem_address(mem_address), .mem_write_enable(mem_write_enable),
        .mem_datain(mem_datain), .busy(busy), .done(done)
`ifdef ROW_COL_LOADER_ERR_EN
        , .stream_err(stream_err)
`endif
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [AB-1:0]    addr;
        logic [RC*DW-1:0] data;
    } wr_t;

    wr_t         sb[$];
    logic [DW-1:0] elems[RC*MS];
    int          n_checks = 0;
    int          n_fail   = 0;
    int          cyc_no   = 0;
    int          done_cnt = 0;
    int          done_cyc = 0;
    int          start_cyc = 0;

    always @(posedge clk) cyc_no <= cyc_no + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference: row r is elems[r*RC .. r*RC+RC-1], element 0 in the LSBs.
    task automatic push_rows(input int first_row, input int nrows);
        for (int r = first_row; r < first_row + nrows; r++) begin
            wr_t w;
            w.addr = AB'(r);
            w.data = '0;
            for (int i = 0; i < RC; i++)
                w.data = w.data | ((RC*DW)'(elems[r*RC+i]) << (DW*i));
            sb.push_back(w);
        end
    endtask

    // Monitor: pops expected writes and tracks done pulses, independent of stimulus.
    always @(negedge clk) begin
        if (mem_write_enable) begin
            if (sb.size() == 0) begin
                check("unexpected_write", 64'(mem_address), 64'hFFFF);
            end else begin
                wr_t w;
                w = sb.pop_front();
                check("write_addr", 64'(mem_address), 64'(w.addr));
                check("write_data", 64'(mem_datain), 64'(w.data));
            end
            check("in_ready_in_write", 64'(in_ready), 64'd0);
        end
        if (nreset && !abort)
            check("in_ready_fill_only", 64'(in_ready), 64'(busy && !mem_write_enable && !done));
        if (done) begin
            done_cnt = done_cnt + 1;
            done_cyc = cyc_no;
        end
    end

    task automatic do_start();
        start = 1'b1;
        start_cyc = cyc_no;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic stream(input int first, input int n, input bit gaps);
        int i = 0;
        int cyc = 0;
        bit acc;
        while (i < n && cyc < 400) begin
            in_valid = gaps ? ($urandom_range(0, 2) != 0) : 1'b1;
            in_data  = elems[first + i];
            acc = in_valid && in_ready;
            @(posedge clk); #1;
            if (acc) i++;
            cyc++;
        end
        in_valid = 1'b0;
        if (i < n) check("stream_timeout", 64'(i), 64'(n));
    endtask

    task automatic wait_done(input int prev);
        int cyc = 0;
        while (done_cnt == prev && cyc < 50) begin
            @(posedge clk); #1;
            cyc++;
        end
        repeat (3) @(posedge clk);
        #1;
        check("done_pulses", 64'(done_cnt - prev), 64'd1);
        check("queue_drained", 64'(sb.size()), 64'd0);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_in_ready"}, 64'(in_ready), 64'd0);
        check({tag, "_we"}, 64'(mem_write_enable), 64'd0);
        check({tag, "_addr"}, 64'(mem_address), 64'd0);
        check({tag, "_datain"}, 64'(mem_datain), 64'd0);
        check({tag, "_busy"}, 64'(busy), 64'd0);
        check({tag, "_done"}, 64'(done), 64'd0);
`ifdef ROW_COL_LOADER_ERR_EN
        check({tag, "_stream_err"}, 64'(stream_err), 64'd0);
`endif
    endtask

    initial begin
        int prev;
        nreset = 1'b0; start = 1'b0; abort = 1'b0; in_valid = 1'b0; in_data = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_reset_outputs("reset");
        @(posedge clk); #1;
        nreset = 1'b1;

`ifdef ROW_COL_LOADER_ERR_EN
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(negedge clk);
        check("err_set", 64'(stream_err), 64'd1);
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("err_sticky", 64'(stream_err), 64'd1);
        @(posedge clk); #1;
        do_start();
        @(negedge clk);
        check("err_cleared", 64'(stream_err), 64'd0);
        @(posedge clk); #1;
        abort = 1'b1;
        @(posedge clk); #1;
        abort = 1'b0;
`endif

        // Basic load with the ramp pattern, including done latency.
        for (int i = 0; i < RC*MS; i++) elems[i] = DW'(i);
        push_rows(0, MS);
        prev = done_cnt;
        do_start();
        stream(0, RC*MS, 1'b0);
        wait_done(prev);
        check("done_latency", 64'(done_cyc - start_cyc), 64'(MS*(RC+1)+1));

        // Same data with random valid gaps.
        push_rows(0, MS);
        prev = done_cnt;
        do_start();
        stream(0, RC*MS, 1'b1);
        wait_done(prev);

        // Abort mid-row: only row 0 written, no done.
        for (int i = 0; i < RC*MS; i++) elems[i] = DW'($urandom);
        push_rows(0, 1);
        prev = done_cnt;
        do_start();
        stream(0, 6, 1'b0);
        abort = 1'b1;
        @(posedge clk); #1;
        abort = 1'b0;
        @(negedge clk);
        check("abort_busy", 64'(busy), 64'd0);
        repeat (4) @(posedge clk);
        #1;
        check("abort_no_done", 64'(done_cnt - prev), 64'd0);
        check("abort_queue", 64'(sb.size()), 64'd0);
        push_rows(0, MS);
        do_start();
        stream(0, RC*MS, 1'b0);
        wait_done(prev);

        // Reset mid-load after 10 elements.
        for (int i = 0; i < RC*MS; i++) elems[i] = DW'($urandom);
        push_rows(0, 2);
        prev = done_cnt;
        do_start();
        stream(0, 10, 1'b0);
        nreset = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check_reset_outputs("midreset");
        @(posedge clk); #1;
        nreset = 1'b1;
        repeat (6) @(posedge clk);
        #1;
        check("midreset_queue", 64'(sb.size()), 64'd0);
        check("midreset_no_done", 64'(done_cnt - prev), 64'd0);
        for (int i = 0; i < RC*MS; i++) elems[i] = DW'(i);
        push_rows(0, MS);
        do_start();
        stream(0, RC*MS, 1'b0);
        wait_done(prev);
        check("reload_latency", 64'(done_cyc - start_cyc), 64'(MS*(RC+1)+1));

        // start pulsed during FILL of row 2 must be ignored.
        for (int i = 0; i < RC*MS; i++) elems[i] = DW'($urandom);
        push_rows(0, MS);
        prev = done_cnt;
        do_start();
        stream(0, 9, 1'b0);
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        stream(9, RC*MS - 9, 1'b0);
        wait_done(prev);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1);
    end
endmodule
